// File: rtl/fejkon_fc_debug_check.sv
// Receive-side checker for FC debug test frames: forwards normal traffic through one
// register stage, verifies/strips generator test frames and keeps saturating counters.
module fejkon_fc_debug_check (
    input  logic         clk,
    input  logic         reset,
    input  logic [3:0]   st_in_channel,
    input  logic [255:0] st_in_data,
    input  logic         st_in_startofpacket,
    input  logic         st_in_endofpacket,
    input  logic [4:0]   st_in_empty,
    input  logic         st_in_valid,
    output logic         st_in_ready,
    output logic [3:0]   st_out_channel,
    output logic [255:0] st_out_data,
    output logic         st_out_startofpacket,
    output logic         st_out_endofpacket,
    output logic [4:0]   st_out_empty,
    output logic         st_out_valid,
    input  logic         st_out_ready,
    input  logic [7:0]   csr_address,
    input  logic         csr_write,
    input  logic         csr_read,
    input  logic [31:0]  csr_writedata,
    output logic [31:0]  csr_readdata
);
    localparam logic [255:0] BEAT0 = {8{32'hdeadbeef}};
    localparam logic [255:0] BEAT1 = {8{32'hbaadc0de}};

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PKT        = 2'd1,
        TEST_B1    = 2'd2,
        TEST_DRAIN = 2'd3
    } state_t;

    state_t           state_reg;
    state_t           state_next;
    logic             strip_reg;
    logic [3:0][31:0] counts;
    logic [3:0]       inc;          // 0 good, 1 bad, 2 proto_err, 3 pkt_fwd
    logic             fwd;
    logic             test_beat;
    logic             accept;
    logic             clear;
    logic             is_b0;
    logic             is_b1;
    logic [31:0]      rdata;
    logic             unused_bits;

    assign unused_bits = ^csr_writedata[31:2];

    assign st_in_ready = ~reset & (~st_out_valid | st_out_ready);
    assign accept      = st_in_valid & st_in_ready;
    assign clear       = csr_write && (csr_address == 8'h00) && csr_writedata[1];
    assign is_b0       = st_in_startofpacket && (st_in_channel == 4'd0) && (st_in_data == BEAT0);
    assign is_b1       = !st_in_startofpacket && st_in_endofpacket && (st_in_channel == 4'd0)
                         && (st_in_empty == 5'd0) && (st_in_data == BEAT1);

    always_comb begin
        state_next = state_reg;
        inc        = '0;
        fwd        = 1'b0;
        test_beat  = 1'b0;
        if (accept) begin
            case (state_reg)
                IDLE, PKT: begin
                    // An SOP+EOP inside a packet just ends it; a bare SOP restarts framing.
                    if (st_in_startofpacket && !(state_reg == PKT && st_in_endofpacket)) begin
                        if (state_reg == PKT) inc[2] = 1'b1;
                        if (is_b0) begin
                            test_beat = 1'b1;
                            if (st_in_endofpacket) begin
                                inc[1]     = 1'b1;
                                state_next = IDLE;
                            end else begin
                                state_next = TEST_B1;
                            end
                        end else begin
                            fwd = 1'b1;
                            if (st_in_endofpacket) begin
                                inc[3]     = 1'b1;
                                state_next = IDLE;
                            end else begin
                                state_next = PKT;
                            end
                        end
                    end else if (state_reg == IDLE) begin
                        inc[2] = 1'b1;
                    end else begin
                        fwd = 1'b1;
                        if (st_in_endofpacket) begin
                            inc[3]     = 1'b1;
                            state_next = IDLE;
                        end
                    end
                end
                TEST_B1: begin
                    test_beat = 1'b1;
                    if (is_b1) begin
                        inc[0]     = 1'b1;
                        state_next = IDLE;
                    end else begin
                        inc[1]     = 1'b1;
                        state_next = st_in_endofpacket ? IDLE : TEST_DRAIN;
                    end
                end
                TEST_DRAIN: begin
                    test_beat = 1'b1;
                    if (st_in_endofpacket) state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
            if (test_beat && !strip_reg) fwd = 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_cnt
            logic [31:0] count_reg;
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    count_reg <= '0;
                end else if (clear) begin
                    count_reg <= '0;
                end else if (inc[gi] && (count_reg != 32'hffffffff)) begin
                    count_reg <= count_reg + 32'd1;
                end
            end
            assign counts[gi] = count_reg;
        end
    endgenerate

    always_comb begin
        rdata = 32'hffffffff;
        case (csr_address)
            8'h00:   rdata = {31'd0, strip_reg};
            8'h01:   rdata = counts[0];
            8'h02:   rdata = counts[1];
            8'h03:   rdata = counts[2];
            8'h04:   rdata = counts[3];
            8'h05:   rdata = {30'd0, state_reg};
            default: rdata = 32'hffffffff;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg            <= IDLE;
            strip_reg            <= 1'b1;
            st_out_channel       <= '0;
            st_out_data          <= '0;
            st_out_startofpacket <= 1'b0;
            st_out_endofpacket   <= 1'b0;
            st_out_empty         <= '0;
            st_out_valid         <= 1'b0;
            csr_readdata         <= '0;
        end else begin
            state_reg <= state_next;
            if (csr_write && (csr_address == 8'h00)) strip_reg <= csr_writedata[0];
            if (fwd) begin
                st_out_channel       <= st_in_channel;
                st_out_data          <= st_in_data;
                st_out_startofpacket <= st_in_startofpacket;
                st_out_endofpacket   <= st_in_endofpacket;
                st_out_empty         <= st_in_empty;
                st_out_valid         <= 1'b1;
            end else if (st_out_ready) begin
                st_out_valid <= 1'b0;
            end
            if (csr_read) csr_readdata <= rdata;
        end
    end
endmodule

// File: tb/tb_fejkon_fc_debug_check.sv
// Directed bench for fejkon_fc_debug_check: frame-level scoreboard model plus literal checks.
module tb_fejkon_fc_debug_check;
    localparam logic [255:0] B0 = {8{32'hdeadbeef}};
    localparam logic [255:0] B1 = {8{32'hbaadc0de}};

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [3:0]   st_in_channel = '0;
    logic [255:0] st_in_data = '0;
    logic         st_in_startofpacket = 1'b0;
    logic         st_in_endofpacket = 1'b0;
    logic [4:0]   st_in_empty = '0;
    logic         st_in_valid = 1'b0;
    logic         st_in_ready;
    logic [3:0]   st_out_channel;
    logic [255:0] st_out_data;
    logic         st_out_startofpacket;
    logic         st_out_endofpacket;
    logic [4:0]   st_out_empty;
    logic         st_out_valid;
    logic         st_out_ready = 1'b1;
    logic [7:0]   csr_address = '0;
    logic         csr_write = 1'b0;
    logic         csr_read = 1'b0;
    logic [31:0]  csr_writedata = '0;
    logic [31:0]  csr_readdata;

    always #5 clk = ~clk;

    fejkon_fc_debug_check dut (
        .clk(clk), .reset(reset),
        .st_in_channel(st_in_channel), .st_in_data(st_in_data),
        .st_in_startofpacket(st_in_startofpacket), .st_in_endofpacket(st_in_endofpacket),
        .st_in_empty(st_in_empty), .st_in_valid(st_in_valid), .st_in_ready(st_in_ready),
        .st_out_channel(st_out_channel), .st_out_data(st_out_data),
        .st_out_startofpacket(st_out_startofpacket), .st_out_endofpacket(st_out_endofpacket),
        .st_out_empty(st_out_empty), .st_out_valid(st_out_valid), .st_out_ready(st_out_ready),
        .csr_address(csr_address), .csr_write(csr_write), .csr_read(csr_read),
        .csr_writedata(csr_writedata), .csr_readdata(csr_readdata)
    );

    typedef struct packed {
        logic [3:0]   ch;
        logic [255:0] data;
        logic         sop;
        logic         eop;
        logic [4:0]   empty;
    } beat_t;

    beat_t       exp_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] m_good = 0, m_bad = 0, m_proto = 0, m_fwd = 0;
    bit          m_strip = 1'b1;
    int          m_open = 0;   // 0 no frame, 1 normal packet, 2 test frame
    int          m_tlen = 0;
    beat_t       held;
    bit          was_held = 1'b0;
    logic [255:0] d0, d1, d2, d3;

    task automatic check(input string name, input logic [271:0] act, input logic [271:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Frame-level model: classify a frame by its opening beat, decide test results on the
    // second test beat, and queue every beat that must appear on the output.
    task automatic model_beat(input beat_t b);
        bit is_b0, is_b1;
        is_b0 = b.sop && b.ch == 4'd0 && b.data == B0;
        is_b1 = !b.sop && b.eop && b.ch == 4'd0 && b.empty == 5'd0 && b.data == B1;
        if (b.sop && (m_open == 0 || (m_open == 1 && !b.eop))) begin
            if (m_open == 1) m_proto++;
            m_open = is_b0 ? 2 : 1;
            m_tlen = 0;
        end else if (m_open == 0) begin
            m_proto++;
            return;
        end
        if (m_open == 2) begin
            m_tlen++;
            if (m_tlen == 1 && b.eop) m_bad++;
            if (m_tlen == 2) begin
                if (is_b1) m_good++;
                else m_bad++;
            end
            if (!m_strip) exp_q.push_back(b);
            if (b.eop) m_open = 0;
        end else begin
            exp_q.push_back(b);
            if (b.eop) begin
                m_fwd++;
                m_open = 0;
            end
        end
    endtask

    task automatic model_ctrl(input logic [31:0] wd);
        m_strip = wd[0];
        if (wd[1]) begin
            m_good = 0; m_bad = 0; m_proto = 0; m_fwd = 0;
        end
    endtask

    function automatic logic [31:0] model_csr(input logic [7:0] a);
        case (a)
            8'h00: return {31'd0, m_strip};
            8'h01: return m_good;
            8'h02: return m_bad;
            8'h03: return m_proto;
            8'h04: return m_fwd;
            8'h05: return (m_open == 0) ? 32'd0 : (m_open == 1) ? 32'd1 : (m_tlen == 1) ? 32'd2 : 32'd3;
            default: return 32'hffffffff;
        endcase
    endfunction

    task automatic monitor();
        beat_t o, e;
        o = {st_out_channel, st_out_data, st_out_startofpacket, st_out_endofpacket, st_out_empty};
        check("in_ready_rule", st_in_ready, !st_out_valid || st_out_ready);
        if (was_held) check("hold_stable", o, held);
        if (st_out_valid && st_out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_beat: got data %h expected no beat", o.data);
            end else begin
                e = exp_q.pop_front();
                check("out_beat", o, e);
            end
        end
        was_held = st_out_valid && !st_out_ready;
        held = o;
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [3:0] ch, input logic [255:0] data, input bit sop,
                             input bit eop, input logic [4:0] empty, input bit with_clear = 1'b0);
        beat_t b;
        bit done;
        done = 1'b0;
        b = {ch, data, sop, eop, empty};
        st_in_channel = ch; st_in_data = data; st_in_startofpacket = sop;
        st_in_endofpacket = eop; st_in_empty = empty; st_in_valid = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            monitor();
            if (st_in_ready) begin
                done = 1'b1;
                model_beat(b);
                if (with_clear) begin
                    csr_write = 1'b1; csr_address = 8'h00; csr_writedata = 32'h3;
                    model_ctrl(32'h3);
                end
            end
            @(posedge clk);
            #1;
        end
        st_in_valid = 1'b0;
        csr_write = 1'b0;
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: got no acceptance expected acceptance within 50 cycles");
        end
        $display("beat ch=%0d sop=%0b eop=%0b empty=%0d data[31:0]=%h", ch, sop, eop, empty, data[31:0]);
    endtask

    task automatic csr_rd(input logic [7:0] a, input logic [31:0] lit, input string name);
        logic [31:0] mexp;
        mexp = model_csr(a);
        csr_address = a; csr_read = 1'b1;
        step();
        csr_read = 1'b0;
        check({name, "_model"}, csr_readdata, mexp);
        check(name, csr_readdata, lit);
        $display("csr read addr=%0h data=%h", a, csr_readdata);
    endtask

    task automatic csr_wr(input logic [7:0] a, input logic [31:0] wd);
        csr_address = a; csr_writedata = wd; csr_write = 1'b1;
        step();
        csr_write = 1'b0;
        if (a == 8'h00) model_ctrl(wd);
        $display("csr write addr=%0h data=%h", a, wd);
    endtask

    initial begin
        d0 = {8{32'h11112222}};
        d1 = {8{32'h33334444}};
        d2 = {8{32'h55556666}};
        d3 = {8{32'h77778888}};

        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", st_out_valid, 0);
        check("reset_out_data", st_out_data, 0);
        check("reset_out_sop", st_out_startofpacket, 0);
        check("reset_readdata", csr_readdata, 0);
        check("reset_in_ready", st_in_ready, 0);
        reset = 1'b0;
        #1;
        check("ready_after_reset", st_in_ready, 1);
        csr_rd(8'h00, 32'd1, "ctrl_reset");
        csr_rd(8'h05, 32'd0, "status_reset");

        // Good test frame, stripped
        send_beat(4'd0, B0, 1, 0, 5'd0);
        send_beat(4'd0, B1, 0, 1, 5'd0);
        repeat (3) step();
        csr_rd(8'h01, 32'd1, "t1_good");
        csr_rd(8'h05, 32'd0, "t1_status");
        csr_rd(8'h04, 32'd0, "t1_fwd");

        // Good test frame, passed through
        csr_wr(8'h00, 32'h0);
        send_beat(4'd0, B0, 1, 0, 5'd0);
        check("t2_lat_b0_valid", st_out_valid, 1);
        check("t2_lat_b0_data", st_out_data, B0);
        send_beat(4'd0, B1, 0, 1, 5'd0);
        check("t2_lat_b1_data", st_out_data, B1);
        check("t2_lat_b1_eop", st_out_endofpacket, 1);
        repeat (3) step();
        csr_rd(8'h01, 32'd2, "t2_good");
        csr_rd(8'h04, 32'd0, "t2_fwd");
        csr_wr(8'h00, 32'h1);

        // Normal 3-beat packet on channel 5 with backpressure
        send_beat(4'd5, d0, 1, 0, 5'd0);
        send_beat(4'd5, d1, 0, 0, 5'd0);
        st_out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            monitor();
            check("t3_ready_low", st_in_ready, 0);
            check("t3_held_data", st_out_data, d1);
            @(posedge clk);
            #1;
        end
        st_out_ready = 1'b1;
        send_beat(4'd5, d2, 0, 1, 5'd3);
        repeat (3) step();
        csr_rd(8'h04, 32'd1, "t3_fwd");

        // Corrupt test frame, then drain
        send_beat(4'd0, B0, 1, 0, 5'd0);
        send_beat(4'd0, '0, 0, 0, 5'd0);
        csr_rd(8'h05, 32'd3, "t4_status_drain");
        send_beat(4'd0, d3, 0, 1, 5'd0);
        repeat (2) step();
        csr_rd(8'h02, 32'd1, "t4_bad");
        csr_rd(8'h05, 32'd0, "t4_status_idle");

        // Stray beat while idle, then clear racing a good frame
        send_beat(4'd2, d0, 0, 1, 5'd0);
        csr_rd(8'h03, 32'd1, "t5_proto");
        send_beat(4'd0, B0, 1, 0, 5'd0);
        send_beat(4'd0, B1, 0, 1, 5'd0, 1'b1);
        step();
        csr_rd(8'h01, 32'd0, "t5_good_cleared");
        csr_rd(8'h03, 32'd0, "t5_proto_cleared");
        csr_rd(8'h00, 32'd1, "t5_ctrl");

        // Address decode and RO writes
        csr_rd(8'h10, 32'hffffffff, "unmapped_addr");
        csr_wr(8'h01, 32'h1234);
        csr_rd(8'h01, 32'd0, "ro_write_ignored");

        // Reset in the middle of a packet
        send_beat(4'd0, B0, 1, 0, 5'd0);
        send_beat(4'd0, B1, 0, 1, 5'd0);
        csr_rd(8'h01, 32'd1, "pre_reset_good");
        send_beat(4'd7, d1, 1, 0, 5'd0);
        check("pre_reset_valid", st_out_valid, 1);
        reset = 1'b1;
        #1;
        check("reset_mid_valid", st_out_valid, 0);
        check("reset_mid_ready", st_in_ready, 0);
        exp_q.delete();
        m_good = 0; m_bad = 0; m_proto = 0; m_fwd = 0;
        m_strip = 1'b1; m_open = 0; m_tlen = 0; was_held = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        csr_rd(8'h01, 32'd0, "post_reset_good");
        csr_rd(8'h02, 32'd0, "post_reset_bad");
        csr_rd(8'h03, 32'd0, "post_reset_proto0");
        csr_rd(8'h04, 32'd0, "post_reset_fwd0");
        send_beat(4'd7, d2, 0, 1, 5'd0);
        repeat (2) step();
        csr_rd(8'h03, 32'd1, "post_reset_proto");
        csr_rd(8'h04, 32'd0, "post_reset_fwd");
        check("queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
